fp32_maxmin_reduce: RTL and testbench
=====================================

# fp32_maxmin_reduce

Streaming FP32 max/min reduction stage that sits directly downstream of the input staging in the fp32_max_min datapath and feeds its result pair to the scalar compare stage. It accepts one FP32 element per cycle over a valid/ready handshake and tracks the running maximum, running minimum, their first-occurrence indices, the element count and a sticky NaN flag. It holds the reduced result for a vector, delimited by `i_last`, on a valid/ready output port until the result is consumed.

## Interface
- `CNT_WIDTH`, default 16: width of the element counter and index outputs.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  input element valid.
- `i_ready`  out  1  stage can accept an element; combinational from state.
- `i_data`  in  32  FP32 element.
- `i_last`  in  1  marks the final element of the vector; sampled on accept.
- `o_valid`  out  1  reduced result valid.
- `o_ready`  in  1  downstream consumes the result.
- `o_max`  out  32  largest non-NaN element.
- `o_min`  out  32  smallest non-NaN element.
- `o_max_idx`  out  CNT_WIDTH  position of the first occurrence of `o_max`, 0-based.
- `o_min_idx`  out  CNT_WIDTH  position of the first occurrence of `o_min`, 0-based.
- `o_cnt`  out  CNT_WIDTH  number of elements accepted, NaNs included; saturating.
- `o_nan_err`  out  1  at least one NaN element in the vector.

## Operation
- NaN: exponent 8'hFF and mantissa ≠ 0. NaNs are never candidates. They set the sticky NaN flag, increment the count and advance the index.
- Ordering is a total order on non-NaN values:
  - Different signs: the positive operand is larger, so −0 < +0.
  - Same sign: compare {exp,mant} as unsigned, with the result inverted when the sign is negative.
  - ±Inf orders normally.
  - Denormals compare by raw bits.
- Ties (bit-identical values) keep the earlier element: max/min and their indices update only on a strictly greater or strictly smaller value.
- The first non-NaN element of a vector loads both max and min and both indices unconditionally. A "have_val" flag tracks this.
- Two states:
  - ACC: `i_ready`=1, `o_valid`=0.
  - OUT: `i_ready`=0, `o_valid`=1.
- Transitions:
  - ACC → OUT on an accepted element with `i_last`=1. That element is included in the result.
  - OUT → ACC when `o_ready`=1. Accumulators, count, index, NaN flag and have_val clear on that same edge.
- Vector of only NaNs: `o_max` = `o_min` = 32'hFFFFFFFF, both indices 0, `o_nan_err`=1.
- Count and index saturate at 2^CNT_WIDTH−1. Elements beyond saturation still participate in max/min and record the saturated index.
- Output registers (`o_max`, `o_min`, `o_max_idx`, `o_min_idx`, `o_cnt`, `o_nan_err`) are stable for the whole time OUT is held. Input data is ignored while `i_ready`=0.
- `i_valid` low in ACC: no state change. A bubble mid-vector is legal.

## Timing
- Reset values:
  - State ACC, so `i_ready`=1.
  - `o_valid`=0.
  - `o_max`, `o_min`, `o_max_idx`, `o_min_idx`, `o_cnt` all 0.
  - `o_nan_err`=0; have_val=0.
- Reset asserted mid-vector or in OUT discards everything immediately and asynchronously. After deassertion the next accepted element starts a new vector at index 0.
- Throughput: one element per cycle in ACC.
- Latency: `o_valid` rises the cycle after the `i_last` element is accepted.
- Minimum gap: one cycle between the last element of vector N and the first element of vector N+1, because OUT holds for at least one cycle.
- `o_valid` && `o_ready` in OUT: the result is consumed on that edge, `o_valid` falls and `i_ready` rises in the next cycle.
- `o_ready` asserted in ACC has no effect.
- Single-element vector (`i_last` on the first element): `o_max` = `o_min` = that element, indices 0, `o_cnt`=1.

## Test plan
- Input {3F800000 (1.0), C0000000 (−2.0), 40600000 (3.5), 3F800000 (1.0, last)}, back-to-back, `o_ready`=1.
  - Expect `o_max`=40600000, `o_max_idx`=2, `o_min`=C0000000, `o_min_idx`=1, `o_cnt`=4, `o_nan_err`=0.
  - `o_valid` is high for exactly 1 cycle, one cycle after the last accept.
- Input {80000000, 00000000, 80000000 (last)}.
  - Expect `o_max`=00000000 idx 1, `o_min`=80000000 idx 0.
- Input {7FC00000, FF800000, 7F800000, 7FC00000 (last)}.
  - Expect `o_max`=7F800000 idx 2, `o_min`=FF800000 idx 1, `o_cnt`=4, `o_nan_err`=1.
- All-NaN vector {7FC00001 (last)}.
  - Expect `o_max`=`o_min`=FFFFFFFF, indices 0, `o_cnt`=1, `o_nan_err`=1.
- Backpressure: hold `o_ready`=0 for 5 cycles after the result appears, with `i_valid`=1 driving new data.
  - `i_ready` stays 0; outputs are stable and no element is consumed.
  - Raise `o_ready`: the next vector starts at index 0 with a clean NaN flag.
- Reset: pulse `rstn` low after 2 elements of a vector.
  - All outputs return to their reset values.
  - The following vector {41200000 (last)} yields `o_max`=`o_min`=41200000, `o_cnt`=1.

Source files
------------

// File: rtl/fp32_maxmin_reduce.sv
// fp32_maxmin_reduce: streaming FP32 max/min reduction with first-occurrence indices,
// saturating count and sticky NaN flag, result held on a valid/ready output port.
module fp32_maxmin_reduce #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [31:0]          i_data,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [31:0]          o_max,
    output logic [31:0]          o_min,
    output logic [CNT_WIDTH-1:0] o_max_idx,
    output logic [CNT_WIDTH-1:0] o_min_idx,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_nan_err
);
    typedef enum logic {ACC, OUT} state_t;

    state_t               state_q, state_d;
    logic [31:0]          max_q, max_d, min_q, min_d;
    logic [CNT_WIDTH-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d, cnt_q, cnt_d;
    logic                 nan_q, nan_d, have_q, have_d;
    logic                 acc, clr, fin, nan, upd_max, upd_min;

    // Total order on non-NaN values: sign first, then magnitude bits (inverted for negatives).
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        return (a[31] != b[31]) ? !a[31] : (a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]));
    endfunction

    always_comb begin
        acc       = (state_q == ACC) && i_valid;
        clr       = (state_q == OUT) && o_ready;
        fin       = acc && i_last;
        nan       = (&i_data[30:23]) && (|i_data[22:0]);
        upd_max   = acc && !nan && (!have_q || gt(i_data, max_q));
        upd_min   = acc && !nan && (!have_q || gt(min_q, i_data));
        have_d    = clr ? 1'b0 : (have_q || (acc && !nan));
        // A vector that closes without any candidate reports all-ones for both extremes.
        max_d     = clr ? '0 : (fin && !have_d) ? '1 : upd_max ? i_data : max_q;
        min_d     = clr ? '0 : (fin && !have_d) ? '1 : upd_min ? i_data : min_q;
        max_idx_d = clr ? '0 : upd_max ? cnt_q : max_idx_q;
        min_idx_d = clr ? '0 : upd_min ? cnt_q : min_idx_q;
        cnt_d     = clr ? '0 : acc ? cnt_q + {{(CNT_WIDTH-1){1'b0}}, ~&cnt_q} : cnt_q;
        nan_d     = clr ? 1'b0 : (nan_q || (acc && nan));
        state_d   = clr ? ACC : fin ? OUT : state_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ACC;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            cnt_q     <= '0;
            nan_q     <= 1'b0;
            have_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            cnt_q     <= cnt_d;
            nan_q     <= nan_d;
            have_q    <= have_d;
        end
    end

    assign i_ready   = (state_q == ACC);
    assign o_valid   = (state_q == OUT);
    assign o_max     = max_q;
    assign o_min     = min_q;
    assign o_max_idx = max_idx_q;
    assign o_min_idx = min_idx_q;
    assign o_cnt     = cnt_q;
    assign o_nan_err = nan_q;
endmodule

// File: tb/tb_fp32_maxmin_reduce.sv
// tb_fp32_maxmin_reduce: directed and randomized vectors against an ordinal-key reference model.
module tb_fp32_maxmin_reduce;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk, rstn, i_valid, i_ready, i_last, o_valid, o_ready, o_nan_err;
    logic [31:0]   i_data, o_max, o_min;
    logic [CW-1:0] o_max_idx, o_min_idx, o_cnt;

    int checks = 0;
    int fails = 0;

    fp32_maxmin_reduce #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready), .o_max(o_max), .o_min(o_min),
        .o_max_idx(o_max_idx), .o_min_idx(o_min_idx), .o_cnt(o_cnt), .o_nan_err(o_nan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Monotonic unsigned key: ordering keys equals the FP total order (-0 < +0).
    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    task automatic model(input logic [31:0] v[$], output logic [31:0] emax, output logic [31:0] emin,
                         output int emi, output int eni, output int ec, output bit en);
        bit have = 0;
        emax = '1; emin = '1; emi = 0; eni = 0; en = 0;
        for (int i = 0; i < v.size(); i++) begin
            int idx = (i > SAT) ? SAT : i;
            if (is_nan(v[i])) en = 1;
            else if (!have) begin
                have = 1; emax = v[i]; emin = v[i]; emi = idx; eni = idx;
            end else begin
                if (key(v[i]) > key(emax)) begin emax = v[i]; emi = idx; end
                if (key(v[i]) < key(emin)) begin emin = v[i]; eni = idx; end
            end
        end
        ec = (v.size() > SAT) ? SAT : v.size();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_i_ready"}, 32'(i_ready), 1);
        chk({tag, "_o_valid"}, 32'(o_valid), 0);
        chk({tag, "_o_max"}, o_max, 0);
        chk({tag, "_o_min"}, o_min, 0);
        chk({tag, "_o_max_idx"}, 32'(o_max_idx), 0);
        chk({tag, "_o_min_idx"}, 32'(o_min_idx), 0);
        chk({tag, "_o_cnt"}, 32'(o_cnt), 0);
        chk({tag, "_o_nan_err"}, 32'(o_nan_err), 0);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] v[$], input bit bubbles, input int hold);
        logic [31:0] emax, emin;
        int emi, eni, ec;
        bit en;
        model(v, emax, emin, emi, eni, ec, en);
        for (int i = 0; i < v.size(); i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                i_valid = 0; i_data = $urandom; i_last = 1; step();
            end
            i_valid = 1; i_data = v[i]; i_last = (i == v.size() - 1);
            for (int b = 0; b < 20 && !i_ready; b++) step();
            chk({tag, "_i_ready_wait"}, 32'(i_ready), 1);
            step();
        end
        i_valid = 0; i_last = 0;
        chk({tag, "_o_valid_latency"}, 32'(o_valid), 1);
        if (hold > 0) begin
            o_ready = 0; i_valid = 1;
            for (int h = 0; h < hold; h++) begin
                i_data = $urandom; i_last = h[0];
                step();
                chk({tag, "_hold_i_ready"}, 32'(i_ready), 0);
                chk({tag, "_hold_o_valid"}, 32'(o_valid), 1);
                chk({tag, "_hold_o_max"}, o_max, emax);
                chk({tag, "_hold_o_cnt"}, 32'(o_cnt), 32'(ec));
            end
            i_valid = 0; i_last = 0; o_ready = 1;
        end
        chk({tag, "_o_max"}, o_max, emax);
        chk({tag, "_o_min"}, o_min, emin);
        chk({tag, "_o_max_idx"}, 32'(o_max_idx), 32'(emi));
        chk({tag, "_o_min_idx"}, 32'(o_min_idx), 32'(eni));
        chk({tag, "_o_cnt"}, 32'(o_cnt), 32'(ec));
        chk({tag, "_o_nan_err"}, 32'(o_nan_err), 32'(en));
        step();
        chk({tag, "_o_valid_fall"}, 32'(o_valid), 0);
        chk({tag, "_i_ready_rise"}, 32'(i_ready), 1);
    endtask

    function automatic logic [31:0] rnd_elem(input logic [31:0] prev[$]);
        logic [31:0] r = $urandom;
        int sel = $urandom_range(0, 9);
        if (sel == 0) begin r[30:23] = 8'hFF; r[0] = 1'b1; end
        else if (sel == 1) r[30:0] = '0;
        else if (sel == 2) begin r[30:23] = 8'hFF; r[22:0] = '0; end
        else if (sel == 3 && prev.size() > 0) r = prev[$urandom_range(0, prev.size() - 1)];
        else if (sel == 4) r[30:23] = '0;
        return r;
    endfunction

    initial begin
        logic [31:0] q[$];
        rstn = 0; i_valid = 0; i_data = 0; i_last = 0; o_ready = 1;
        step(); step();
        check_reset_vals("por");
        rstn = 1;
        step();

        q = '{32'h3F800000, 32'hC0000000, 32'h40600000, 32'h3F800000};
        run_vec("mixed", q, 0, 0);
        q = '{32'h80000000, 32'h00000000, 32'h80000000};
        run_vec("zeros", q, 0, 0);
        q = '{32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h7FC00000};
        run_vec("inf_nan", q, 0, 0);
        q = '{32'h7FC00001};
        run_vec("all_nan", q, 0, 0);
        q = '{32'h40000000, 32'h7FC00000, 32'hBF800000};
        run_vec("bp", q, 0, 5);
        q = '{32'h40400000, 32'h40400000, 32'h3F000000};
        run_vec("after_bp", q, 0, 0);
        q = '{32'h3F800000};
        run_vec("single", q, 0, 0);

        i_valid = 1; i_last = 0;
        i_data = 32'h40400000; step();
        i_data = 32'hC1000000; step();
        i_valid = 0;
        #1 rstn = 0;
        #1 check_reset_vals("async_rst");
        step();
        rstn = 1;
        step();
        q = '{32'h41200000};
        run_vec("post_rst", q, 0, 0);

        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(32'h3F800000 + 32'(i));
        q.push_back(32'hBF800000);
        run_vec("saturate", q, 1, 0);

        for (int n = 0; n < 40; n++) begin
            int len = $urandom_range(1, 9);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(rnd_elem(q));
            run_vec("rand", q, 1, (n % 8 == 7) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
